// File: rtl/muldiv_if.sv
// Request/response bundle between the pipeline and the multiply/divide unit.
interface muldiv_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, cancel, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, cancel, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_ctrl.sv
// Iterative HI/LO multiply/divide unit: one shift-add or restoring
// shift-subtract step per cycle, sign fixed up in a final writeback state.
module muldiv_ctrl #(
    parameter int ITER = 32
) (
    input  logic     clk,
    input  logic     rst,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t        r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [63:0]   r_acc;
    logic [31:0]   r_mb;
    logic [31:0]   r_a_raw;
    logic          r_is_div, r_neg_q, r_neg_r, r_done;
    logic [31:0]   r_hi, r_lo;

    logic          w_idle_start, w_accept, w_signed, w_wb;
    logic [31:0]   w_mag_a, w_mag_b;
    logic [32:0]   w_madd, w_prem, w_dsub;
    logic          w_ge;
    logic [63:0]   w_mul_acc, w_div_acc, w_prod;
    logic [31:0]   w_quot, w_rem, w_res_hi, w_res_lo;

    assign w_idle_start = (r_state == IDLE) && bus.start;
    assign w_accept     = w_idle_start && !bus.op[2];
    assign w_signed     = !bus.op[0];
    assign w_mag_a      = (w_signed && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
    assign w_mag_b      = (w_signed && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

    // Multiply: low half holds the multiplier, shifted out LSB-first.
    assign w_madd    = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_mb : 32'd0)};
    assign w_mul_acc = {w_madd, r_acc[31:1]};

    // Divide: 33-bit partial remainder so 2*rem+bit never overflows.
    assign w_prem    = r_acc[63:31];
    assign w_ge      = w_prem >= {1'b0, r_mb};
    assign w_dsub    = w_prem - {1'b0, r_mb};
    assign w_div_acc = w_ge ? {w_dsub[31:0], r_acc[30:0], 1'b1} : {r_acc[62:0], 1'b0};

    assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
    assign w_quot = r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
    assign w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_comb begin
        w_res_hi = w_prod[63:32];
        w_res_lo = w_prod[31:0];
        if (r_is_div) begin
            if (r_mb == 32'd0) begin
                w_res_hi = r_a_raw;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_rem;
                w_res_lo = w_quot;
            end
        end
    end

    // Cancel beats the FINISH writeback.
    assign w_wb = (r_state == FINISH) && !bus.cancel;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = CALC;
            CALC:    if (bus.cancel) w_next = IDLE;
                     else if (r_cnt == CW'(ITER - 1)) w_next = FINISH;
            FINISH:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mb     <= '0;
            r_a_raw  <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= w_wb;
            if (w_accept) begin
                r_cnt    <= '0;
                r_a_raw  <= bus.a;
                r_is_div <= bus.op[1];
                r_neg_q  <= w_signed && (bus.a[31] ^ bus.b[31]);
                r_neg_r  <= w_signed && bus.a[31];
                r_mb     <= bus.op[1] ? w_mag_b : w_mag_a;
                r_acc    <= {32'd0, (bus.op[1] ? w_mag_a : w_mag_b)};
            end else if (r_state == CALC && !bus.cancel) begin
                r_acc <= r_is_div ? w_div_acc : w_mul_acc;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_wb) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (w_idle_start && bus.op == 3'b100) begin
                r_hi <= bus.a;
            end else if (w_idle_start && bus.op == 3'b101) begin
                r_lo <= bus.a;
            end
        end
    end

    assign bus.busy = (r_state != IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
